// File: rtl/dbus_mem_responder_if.sv
//------------------------------------------------------------------------------
// Module      : dbus_mem_responder_if
// Description : dbus data-memory request/response bundle. The master modport is
//               the initiator (DMA engine / LSU); the slave modport is the
//               memory responder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface dbus_mem_responder_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDRWIDTH  = 32
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic [ADDRWIDTH-1:0]  dbus_address;
  logic [DATA_WIDTH-1:0] dbus_writedata;
  logic [BYTES-1:0]      dbus_byteen;
  logic                  dbus_en;
  logic                  dbus_wren;
  logic                  dbus_prefetch;
  logic [DATA_WIDTH-1:0] dbus_readdata;
  logic                  dbus_wait;
  logic                  dbus_data_valid;

  modport master (
    output dbus_address, dbus_writedata, dbus_byteen, dbus_en, dbus_wren, dbus_prefetch,
    input  dbus_readdata, dbus_wait, dbus_data_valid
  );

  modport slave (
    input  dbus_address, dbus_writedata, dbus_byteen, dbus_en, dbus_wren, dbus_prefetch,
    output dbus_readdata, dbus_wait, dbus_data_valid
  );
endinterface

`default_nettype wire

// File: rtl/dbus_mem_responder.sv
//------------------------------------------------------------------------------
// Module      : dbus_mem_responder
// Description : Single-beat dbus responder backed by a word-wide on-chip array.
//               Reads take READ_LATENCY wait cycles followed by a one-cycle
//               data-valid pulse; writes take WRITE_LATENCY wait cycles and
//               commit with per-byte enables; prefetches are acknowledged with
//               one wait cycle and return nothing.
//               Optional macro DBUS_RESP_STATS_EN adds saturating read/write
//               completion counters (stat_rd_count, stat_wr_count).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module dbus_mem_responder #(
  parameter int DATA_WIDTH     = 128,
  parameter int ADDRWIDTH      = 32,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int READ_LATENCY   = 2,
  parameter int WRITE_LATENCY  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  dbus_mem_responder_if.slave  dbus,
  output logic                 resp_busy
`ifdef DBUS_RESP_STATS_EN
  ,
  output logic [15:0]          stat_rd_count,
  output logic [15:0]          stat_wr_count
`endif
);

  localparam int c_BYTES   = DATA_WIDTH / 8;
  localparam int c_OFS     = $clog2(c_BYTES);
  localparam int c_DEPTH   = 1 << MEM_DEPTH_LOG2;
  localparam int c_MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int c_CNT_W   = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;

  localparam logic [c_CNT_W-1:0] c_RD_CNT_INIT = c_CNT_W'(READ_LATENCY - 1);
  localparam logic [c_CNT_W-1:0] c_WR_CNT_INIT = c_CNT_W'(WRITE_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_DONE = 3'd2,
    WR_WAIT = 3'd3,
    PF_WAIT = 3'd4
  } state_t;

  state_t                    r_state;
  logic [c_CNT_W-1:0]        r_cnt;
  logic [MEM_DEPTH_LOG2-1:0] r_idx;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [c_BYTES-1:0]        r_byteen;
  logic [DATA_WIDTH-1:0]     r_mem [c_DEPTH];
  logic                      w_wr_commit;
  logic                      w_unused_addr;

  // Sub-word offset bits and alias bits above the index are intentionally ignored.
  assign w_unused_addr = ^dbus.dbus_address;

  // The write lands on the final wait edge; a concurrent reset discards it.
  assign w_wr_commit = reset && (r_state == WR_WAIT) && (r_cnt == '0);

  assign resp_busy = (r_state != IDLE);

  // Request FSM: accept in IDLE, count wait cycles, drive registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state              <= IDLE;
      r_cnt                <= '0;
      dbus.dbus_wait       <= 1'b0;
      dbus.dbus_data_valid <= 1'b0;
      dbus.dbus_readdata   <= '0;
    end else begin
      dbus.dbus_data_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (dbus.dbus_en) begin
            r_idx          <= dbus.dbus_address[c_OFS +: MEM_DEPTH_LOG2];
            r_wdata        <= dbus.dbus_writedata;
            r_byteen       <= dbus.dbus_byteen;
            dbus.dbus_wait <= 1'b1;
            // A write with the prefetch hint set is still a write.
            if (dbus.dbus_wren) begin
              r_cnt   <= c_WR_CNT_INIT;
              r_state <= WR_WAIT;
            end else if (dbus.dbus_prefetch) begin
              r_cnt   <= '0;
              r_state <= PF_WAIT;
            end else begin
              r_cnt   <= c_RD_CNT_INIT;
              r_state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (r_cnt == '0) begin
            dbus.dbus_readdata   <= r_mem[r_idx];
            dbus.dbus_wait       <= 1'b0;
            dbus.dbus_data_valid <= 1'b1;
            r_state              <= RD_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RD_DONE: begin
          r_state <= IDLE;
        end
        WR_WAIT: begin
          if (r_cnt == '0) begin
            dbus.dbus_wait <= 1'b0;
            r_state        <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        PF_WAIT: begin
          dbus.dbus_wait <= 1'b0;
          r_state        <= IDLE;
        end
        default: begin
          dbus.dbus_wait <= 1'b0;
          r_state        <= IDLE;
        end
      endcase
    end
  end

  // Array write port with per-byte enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_commit) begin
      for (int b = 0; b < c_BYTES; b++) begin
        if (r_byteen[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

`ifdef DBUS_RESP_STATS_EN
  logic [15:0] r_stat_rd_count;
  logic [15:0] r_stat_wr_count;

  // Saturating completion counters; prefetches never reach RD_DONE or a commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stat_rd_count <= '0;
      r_stat_wr_count <= '0;
    end else begin
      if ((r_state == RD_DONE) && (r_stat_rd_count != 16'hFFFF)) begin
        r_stat_rd_count <= r_stat_rd_count + 16'd1;
      end
      if (w_wr_commit && (r_stat_wr_count != 16'hFFFF)) begin
        r_stat_wr_count <= r_stat_wr_count + 16'd1;
      end
    end
  end

  assign stat_rd_count = r_stat_rd_count;
  assign stat_wr_count = r_stat_wr_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dbus_mem_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_dbus_mem_responder
// Description : Directed self-checking bench for dbus_mem_responder.
//               Define DBUS_RESP_STATS_EN to also exercise the statistics counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_dbus_mem_responder;

  logic clk = 1'b0;
  logic reset;
  logic resp_busy;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dbus_mem_responder_if #(.DATA_WIDTH(128), .ADDRWIDTH(32)) bus ();

`ifdef DBUS_RESP_STATS_EN
  logic [15:0] stat_rd_count;
  logic [15:0] stat_wr_count;
`endif

  dbus_mem_responder #(
    .DATA_WIDTH(128), .ADDRWIDTH(32), .MEM_DEPTH_LOG2(10),
    .READ_LATENCY(2), .WRITE_LATENCY(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dbus(bus),
    .resp_busy(resp_busy)
`ifdef DBUS_RESP_STATS_EN
    ,
    .stat_rd_count(stat_rd_count),
    .stat_wr_count(stat_wr_count)
`endif
  );

  localparam logic [127:0] D1   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D3   = 128'h00112233_44556677_8899AABB_00000000;
  localparam logic [127:0] D80  = 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C;
  localparam logic [127:0] DBAD = 128'hDEADDEAD_DEADDEAD_DEADDEAD_DEADDEAD;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction: accept, count wait cycles (bounded), then sample completion.
  task automatic xact(input logic [31:0] a, input logic [127:0] d, input logic [15:0] be,
                      input logic wr, input logic pf,
                      output int wcyc, output logic vld_in_wait, output logic vld,
                      output logic [127:0] rd, output logic vld_after, output logic busy_after);
    bus.dbus_address   = a;
    bus.dbus_writedata = d;
    bus.dbus_byteen    = be;
    bus.dbus_wren      = wr;
    bus.dbus_prefetch  = pf;
    bus.dbus_en        = 1'b1;
    tick();
    bus.dbus_en = 1'b0;
    wcyc        = 0;
    vld_in_wait = 1'b0;
    while (bus.dbus_wait && wcyc < 20) begin
      wcyc++;
      if (bus.dbus_data_valid) vld_in_wait = 1'b1;
      tick();
    end
    vld = bus.dbus_data_valid;
    rd  = bus.dbus_readdata;
    tick();
    vld_after  = bus.dbus_data_valid;
    busy_after = resp_busy;
  endtask

  int           wc;
  logic         viw, v, va, ba;
  logic [127:0] rd;

  initial begin
    reset              = 1'b0;
    bus.dbus_address   = '0;
    bus.dbus_writedata = '0;
    bus.dbus_byteen    = '0;
    bus.dbus_en        = 1'b0;
    bus.dbus_wren      = 1'b0;
    bus.dbus_prefetch  = 1'b0;

    // 1. Reset held two cycles, then idle with no request.
    tick();
    tick();
    check("rst_wait",  bus.dbus_wait,       1'b0);
    check("rst_valid", bus.dbus_data_valid, 1'b0);
    check("rst_busy",  resp_busy,           1'b0);
    check("rst_rdata", bus.dbus_readdata,   128'h0);
    reset = 1'b1;
    tick();
    tick();
    tick();
    check("idle_outs", {bus.dbus_wait, bus.dbus_data_valid, resp_busy}, 3'b000);

    // 2. Full write then read back.
    xact(32'h40, D1, 16'hFFFF, 1'b1, 1'b0, wc, viw, v, rd, va, ba);
    check("wr1_waitcyc", wc, 1);
    check("wr1_novalid", {viw, v, va}, 3'b000);
    check("wr1_idle",    ba, 1'b0);
    xact(32'h40, '0, '0, 1'b0, 1'b0, wc, viw, v, rd, va, ba);
    check("rd1_waitcyc", wc, 2);
    check("rd1_valid",   {viw, v, va}, 3'b010);
    check("rd1_data",    rd, D1);
    check("rd1_idle",    ba, 1'b0);
    check("rd1_hold",    bus.dbus_readdata, D1);

    // 3. Partial write of the low four bytes.
    xact(32'h40, 128'h0, 16'h000F, 1'b1, 1'b0, wc, viw, v, rd, va, ba);
    check("wr2_waitcyc", wc, 1);
    xact(32'h40, '0, '0, 1'b0, 1'b0, wc, viw, v, rd, va, ba);
    check("rd2_data", rd, D3);

    // Seed 0x80 with known contents for the later scenarios.
    xact(32'h80, D80, 16'hFFFF, 1'b1, 1'b0, wc, viw, v, rd, va, ba);
    check("wr80_waitcyc", wc, 1);

    // byteen=0 write: full handshake, array untouched.
    xact(32'h80, DBAD, 16'h0000, 1'b1, 1'b0, wc, viw, v, rd, va, ba);
    check("wr_be0_waitcyc", wc, 1);

    // 4. Requests during RD_WAIT and RD_DONE are ignored.
    bus.dbus_address = 32'h40;
    bus.dbus_wren    = 1'b0;
    bus.dbus_en      = 1'b1;
    tick();
    bus.dbus_address   = 32'h80;
    bus.dbus_writedata = DBAD;
    bus.dbus_byteen    = 16'hFFFF;
    bus.dbus_wren      = 1'b1;
    check("ign_wait1", bus.dbus_wait, 1'b1);
    tick();
    check("ign_wait2", bus.dbus_wait, 1'b1);
    tick();
    check("ign_done", {bus.dbus_wait, bus.dbus_data_valid}, 2'b01);
    check("ign_data", bus.dbus_readdata, D3);
    tick();
    bus.dbus_en = 1'b0;
    check("ign_notaccepted", {resp_busy, bus.dbus_wait, bus.dbus_data_valid}, 3'b000);
    tick();
    check("ign_stillidle", resp_busy, 1'b0);
    xact(32'h40 + (32'h1 << 14), '0, '0, 1'b0, 1'b0, wc, viw, v, rd, va, ba);
    check("alias_data", rd, D3);

    // 5. Prefetch: one wait cycle, no valid pulse.
    xact(32'h80, '0, '0, 1'b0, 1'b1, wc, viw, v, rd, va, ba);
    check("pf_waitcyc", wc, 1);
    check("pf_novalid", {viw, v, va}, 3'b000);
    check("pf_idle",    ba, 1'b0);

    // Write+prefetch is a write.
    xact(32'h100, D1, 16'hFFFF, 1'b1, 1'b1, wc, viw, v, rd, va, ba);
    xact(32'h100, '0, '0, 1'b0, 1'b0, wc, viw, v, rd, va, ba);
    check("wrpf_data", rd, D1);

    // Reset during WR_WAIT discards the write.
    bus.dbus_address   = 32'h80;
    bus.dbus_writedata = DBAD;
    bus.dbus_byteen    = 16'hFFFF;
    bus.dbus_wren      = 1'b1;
    bus.dbus_prefetch  = 1'b0;
    bus.dbus_en        = 1'b1;
    tick();
    bus.dbus_en = 1'b0;
    check("mid_wrwait", {bus.dbus_wait, resp_busy}, 2'b11);
    reset = 1'b0;
    tick();
    check("mid_rst_outs", {bus.dbus_wait, bus.dbus_data_valid, resp_busy}, 3'b000);
    reset = 1'b1;
    tick();
    xact(32'h80, '0, '0, 1'b0, 1'b0, wc, viw, v, rd, va, ba);
    check("mid_rst_old", rd, D80);
    check("mid_rst_rdv", {viw, v, va}, 3'b010);

    // Reset during RD_WAIT returns nothing.
    bus.dbus_address = 32'h80;
    bus.dbus_wren    = 1'b0;
    bus.dbus_en      = 1'b1;
    tick();
    bus.dbus_en = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rdabort_outs", {bus.dbus_wait, bus.dbus_data_valid, resp_busy}, 3'b000);
    tick();
    tick();
    check("rdabort_novalid", {bus.dbus_wait, bus.dbus_data_valid, resp_busy}, 3'b000);

`ifdef DBUS_RESP_STATS_EN
    // 6. Counters: 3 reads, 2 writes, 1 prefetch after a fresh reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("stat_rst", {stat_rd_count, stat_wr_count}, 32'h0);
    for (int i = 0; i < 3; i++) xact(32'h40, '0, '0, 1'b0, 1'b0, wc, viw, v, rd, va, ba);
    for (int i = 0; i < 2; i++) xact(32'h200, D1, 16'hFFFF, 1'b1, 1'b0, wc, viw, v, rd, va, ba);
    xact(32'h40, '0, '0, 1'b0, 1'b1, wc, viw, v, rd, va, ba);
    check("stat_rd", stat_rd_count, 16'd3);
    check("stat_wr", stat_wr_count, 16'd2);
    dut.r_stat_rd_count = 16'hFFFF;
    xact(32'h40, '0, '0, 1'b0, 1'b0, wc, viw, v, rd, va, ba);
    check("stat_sat", stat_rd_count, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
